// File: rtl/ram_writer_pkg.sv
// Shared state encoding, width helpers and default timing for the packed-sample RAM writer.
package ram_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } state_t;

  localparam int DEFAULT_PERIOD     = 500000;
  localparam int DEFAULT_INIT_DELAY = 5;

  function automatic int data_w(input int num_ch, input int sample_w);
    return num_ch * sample_w;
  endfunction

  function automatic int be_w(input int num_ch, input int sample_w);
    return (num_ch * sample_w) / 8;
  endfunction

endpackage

// File: rtl/sample_period_timer.sv
// Loadable down-counter; tc_o is high while the count rests at zero (one cycle after
// loading N, tc_o rises N cycles later). No backpressure: load simply overrides counting.
module sample_period_timer #(
  parameter int CNT_W = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/ram_sample_writer.sv
// Packs NUM_CH samples per RAM word and writes them with a one-cycle strobe over a circular
// or one-shot address range; external samples land one cycle after valid, and are dropped if not waiting.
module ram_sample_writer
  import ram_writer_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int SAMPLE_W   = 16,
  parameter int ADDR_W     = 14,
  parameter int ADDR_FIRST = 1,
  parameter int ADDR_LAST  = 2**ADDR_W - 1,
  parameter int PERIOD     = DEFAULT_PERIOD,
  parameter int INIT_DELAY = DEFAULT_INIT_DELAY
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  input  logic                           i_stop,
  input  logic                           i_oneshot,
  input  logic                           i_ext_mode,
  input  logic [NUM_CH-1:0]              i_ch_en,
  input  logic                           i_ext_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0]     i_ext_data,
  output logic [NUM_CH*SAMPLE_W-1:0]     o_data,
  output logic [ADDR_W-1:0]              o_address,
  output logic [NUM_CH*SAMPLE_W/8-1:0]   o_byteen,
  output logic                           o_wbit,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_overrun,
  output logic [31:0]                    o_wr_count
);

  localparam int DATA_W = data_w(NUM_CH, SAMPLE_W);
  localparam int BE_W   = be_w(NUM_CH, SAMPLE_W);
  localparam int BPC    = SAMPLE_W / 8;
  localparam int TMAX   = (PERIOD > INIT_DELAY) ? PERIOD : INIT_DELAY;
  localparam int CNT_W  = $clog2(TMAX + 1);
  localparam logic [ADDR_W-1:0] A_FIRST = ADDR_W'(ADDR_FIRST);
  localparam logic [ADDR_W-1:0] A_LAST  = ADDR_W'(ADDR_LAST);

  function automatic logic [DATA_W-1:0] pat_init();
    logic [DATA_W-1:0] p;
    p = '0;
    for (int k = 0; k < NUM_CH; k++) p[k*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(k);
    return p;
  endfunction

  function automatic logic [BE_W-1:0] expand_be(input logic [NUM_CH-1:0] en);
    logic [BE_W-1:0] b;
    b = '0;
    for (int k = 0; k < NUM_CH; k++) b[k*BPC +: BPC] = {BPC{en[k]}};
    return b;
  endfunction

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   pat_q, pat_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [31:0]         wr_count_q, wr_count_d;
  logic                done_q, done_d;
  logic                overrun_q, overrun_d;
  logic                oneshot_q, oneshot_d;
  logic                ext_mode_q, ext_mode_d;
  logic [NUM_CH-1:0]   ch_en_q, ch_en_d;
  logic                tmr_load;
  logic [CNT_W-1:0]    tmr_val;
  logic                tmr_tc;

  sample_period_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    pat_d       = pat_q;
    addr_d      = addr_q;
    next_addr_d = next_addr_q;
    be_d        = be_q;
    wr_count_d  = wr_count_q;
    done_d      = done_q;
    overrun_d   = overrun_q;
    oneshot_d   = oneshot_q;
    ext_mode_d  = ext_mode_q;
    ch_en_d     = ch_en_q;
    tmr_load    = 1'b0;
    tmr_val     = CNT_W'(INIT_DELAY - 1);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start && !i_stop) begin
          state_d     = ST_INIT;
          oneshot_d   = i_oneshot;
          ext_mode_d  = i_ext_mode;
          ch_en_d     = i_ch_en;
          next_addr_d = A_FIRST;
          pat_d       = pat_init();
          done_d      = 1'b0;
          overrun_d   = 1'b0;
          wr_count_d  = '0;
          tmr_load    = 1'b1;
        end
      end
      ST_INIT: begin
        if (i_stop) begin
          state_d = ST_IDLE;
        end else if (tmr_tc) begin
          state_d  = ST_WAIT;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(PERIOD - 1);
        end
      end
      ST_WAIT: begin
        if (i_stop) begin
          state_d = ST_IDLE;
        end else if (ext_mode_q ? i_ext_valid : tmr_tc) begin
          state_d = ST_WRITE;
          data_d  = ext_mode_q ? i_ext_data : pat_q;
          addr_d  = next_addr_q;
          be_d    = expand_be(ch_en_q);
        end
      end
      ST_WRITE: begin
        // The strobe cycle itself counts toward the next period, hence PERIOD-2.
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(PERIOD - 2);
        if (wr_count_q != '1) wr_count_d = wr_count_q + 32'd1;
        if (!ext_mode_q) begin
          for (int k = 0; k < NUM_CH; k++)
            pat_d[k*SAMPLE_W +: SAMPLE_W] = pat_q[k*SAMPLE_W +: SAMPLE_W] + SAMPLE_W'(NUM_CH);
        end
        next_addr_d = (addr_q == A_LAST) ? A_FIRST : addr_q + ADDR_W'(1);
        if (i_stop) begin
          state_d = ST_IDLE;
        end else if ((addr_q == A_LAST) && oneshot_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (ext_mode_q && i_ext_valid && (state_q == ST_INIT || state_q == ST_WRITE))
      overrun_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      pat_q       <= pat_init();
      addr_q      <= '0;
      next_addr_q <= A_FIRST;
      be_q        <= '0;
      wr_count_q  <= '0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      oneshot_q   <= 1'b0;
      ext_mode_q  <= 1'b0;
      ch_en_q     <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      pat_q       <= pat_d;
      addr_q      <= addr_d;
      next_addr_q <= next_addr_d;
      be_q        <= be_d;
      wr_count_q  <= wr_count_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
      oneshot_q   <= oneshot_d;
      ext_mode_q  <= ext_mode_d;
      ch_en_q     <= ch_en_d;
    end
  end

  assign o_data     = data_q;
  assign o_address  = addr_q;
  assign o_byteen   = be_q;
  assign o_wbit     = (state_q == ST_WRITE);
  assign o_busy     = (state_q == ST_INIT) || (state_q == ST_WAIT) || (state_q == ST_WRITE);
  assign o_done     = done_q;
  assign o_overrun  = overrun_q;
  assign o_wr_count = wr_count_q;

endmodule

// File: tb/tb_ram_sample_writer.sv
// Scoreboard bench for ram_sample_writer: expected writes are queued from an arithmetic model
// and a negedge monitor pops and compares each strobe.
module tb_ram_sample_writer;

  localparam int NUM_CH = 4, SAMPLE_W = 16, ADDR_W = 14;
  localparam int ADDR_FIRST = 1, ADDR_LAST = 4, PERIOD = 8, INIT_DELAY = 5;
  localparam int NADDR = ADDR_LAST - ADDR_FIRST + 1;

  logic        clk = 1'b0;
  logic        i_rst, i_start, i_stop, i_oneshot, i_ext_mode, i_ext_valid;
  logic [3:0]  i_ch_en;
  logic [63:0] i_ext_data;
  logic [63:0] o_data;
  logic [13:0] o_address;
  logic [7:0]  o_byteen;
  logic        o_wbit, o_busy, o_done, o_overrun;
  logic [31:0] o_wr_count;

  ram_sample_writer #(
    .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .ADDR_W(ADDR_W),
    .ADDR_FIRST(ADDR_FIRST), .ADDR_LAST(ADDR_LAST),
    .PERIOD(PERIOD), .INIT_DELAY(INIT_DELAY)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_stop(i_stop),
    .i_oneshot(i_oneshot), .i_ext_mode(i_ext_mode), .i_ch_en(i_ch_en),
    .i_ext_valid(i_ext_valid), .i_ext_data(i_ext_data),
    .o_data(o_data), .o_address(o_address), .o_byteen(o_byteen), .o_wbit(o_wbit),
    .o_busy(o_busy), .o_done(o_done), .o_overrun(o_overrun), .o_wr_count(o_wr_count)
  );

  typedef struct {
    logic [63:0] data;
    logic [13:0] addr;
    logic [7:0]  be;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0, errors = 0, cyc = 0, wbit_seen = 0, ext_j = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: write j of a run lands at address FIRST+(j mod range); channel c holds j*NUM_CH+c.
  function automatic logic [7:0] model_be(input logic [3:0] en);
    logic [7:0] b = '0;
    for (int c = 0; c < NUM_CH; c++) if (en[c]) b |= 8'(3) << (2 * c);
    return b;
  endfunction

  function automatic logic [13:0] model_addr(input int j);
    return 14'(ADDR_FIRST + (j % NADDR));
  endfunction

  task automatic push_internal(input int t0, input int n, input logic [3:0] en);
    exp_t e;
    for (int j = 0; j < n; j++) begin
      for (int c = 0; c < NUM_CH; c++) e.data[c*16 +: 16] = 16'(j * NUM_CH + c);
      e.addr = model_addr(j);
      e.be   = model_be(en);
      e.cyc  = t0 + 1 + INIT_DELAY + PERIOD * (j + 1);
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (o_wbit) begin
      wbit_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h with nothing expected (cycle %0d)", o_address, o_data, cyc);
      end else begin
        e = sb.pop_front();
        chk("wr_data", o_data, e.data);
        chk("wr_addr", 64'(o_address), 64'(e.addr));
        chk("wr_byteen", 64'(o_byteen), 64'(e.be));
        chk("wr_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic start_run(input logic os, input logic ext, input logic [3:0] en, output int t0);
    i_oneshot = os; i_ext_mode = ext; i_ch_en = en; i_start = 1'b1;
    t0 = cyc;
    tick(1);
    i_start = 1'b0;
    // Scramble the latched controls to show they are ignored mid-run.
    i_oneshot = 1'($urandom); i_ext_mode = 1'($urandom); i_ch_en = 4'($urandom);
  endtask

  task automatic stop_pulse();
    i_stop = 1'b1;
    tick(1);
    i_stop = 1'b0;
  endtask

  task automatic ext_sample(input logic [63:0] d, input logic expect_wr);
    exp_t e;
    if (expect_wr) begin
      e.data = d; e.addr = model_addr(ext_j); e.be = model_be(4'hF); e.cyc = cyc + 1;
      sb.push_back(e);
      ext_j++;
    end
    i_ext_valid = 1'b1; i_ext_data = d;
    tick(1);
    i_ext_valid = 1'b0; i_ext_data = {$urandom(), $urandom()};
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"}, o_data, 64'd0);
    chk({tag, "_addr"}, 64'(o_address), 64'd0);
    chk({tag, "_byteen"}, 64'(o_byteen), 64'd0);
    chk({tag, "_wbit"}, 64'(o_wbit), 64'd0);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
    chk({tag, "_done"}, 64'(o_done), 64'd0);
    chk({tag, "_overrun"}, 64'(o_overrun), 64'd0);
    chk({tag, "_count"}, 64'(o_wr_count), 64'd0);
  endtask

  initial begin
    int t0, w0, c;
    logic [3:0] en;
    i_rst = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_oneshot = 1'b0; i_ext_mode = 1'b0;
    i_ch_en = 4'h0; i_ext_valid = 1'b0; i_ext_data = '0;
    tick(3);
    chk_zero("reset");
    i_rst = 1'b0;
    w0 = wbit_seen;
    tick(20);
    chk("reset_quiet", 64'(wbit_seen - w0), 64'd0);

    // Internal pattern, wrapping address range.
    start_run(1'b0, 1'b0, 4'hF, t0);
    push_internal(t0, 6, 4'hF);
    chk("init_busy", 64'(o_busy), 64'd1);
    wait_until(t0 + 56);
    stop_pulse();
    chk("wrap_stop_busy", 64'(o_busy), 64'd0);
    chk("wrap_count", 64'(o_wr_count), 64'd6);
    chk("wrap_addr_hold", 64'(o_address), 64'(model_addr(5)));
    chk("wrap_drained", 64'(sb.size()), 64'd0);

    // One-shot with a random channel mask.
    en = 4'($urandom_range(1, 15));
    start_run(1'b1, 1'b0, en, t0);
    push_internal(t0, 4, en);
    wait_until(t0 + 1 + INIT_DELAY + 4 * PERIOD + 1);
    chk("oneshot_done", 64'(o_done), 64'd1);
    chk("oneshot_busy", 64'(o_busy), 64'd0);
    chk("oneshot_count", 64'(o_wr_count), 64'd4);
    chk("oneshot_addr", 64'(o_address), 64'(ADDR_LAST));
    w0 = wbit_seen;
    tick(100);
    chk("oneshot_quiet", 64'(wbit_seen - w0), 64'd0);

    // Restart with mask 0101: address/pattern restart, done clears.
    start_run(1'b0, 1'b0, 4'b0101, t0);
    push_internal(t0, 2, 4'b0101);
    chk("restart_done_clr", 64'(o_done), 64'd0);
    chk("restart_count_clr", 64'(o_wr_count), 64'd0);
    wait_until(t0 + 25);
    stop_pulse();
    chk("mask_byteen", 64'(o_byteen), 64'h33);
    chk("mask_count", 64'(o_wr_count), 64'd2);

    // Stop while the strobe is high.
    en = 4'($urandom);
    start_run(1'b0, 1'b0, en, t0);
    push_internal(t0, 1, en);
    wait_until(t0 + 1 + INIT_DELAY + PERIOD);
    stop_pulse();
    chk("stopwr_busy", 64'(o_busy), 64'd0);
    chk("stopwr_count", 64'(o_wr_count), 64'd1);
    chk("stopwr_addr", 64'(o_address), 64'd1);
    w0 = wbit_seen;
    tick(30);
    chk("stopwr_quiet", 64'(wbit_seen - w0), 64'd0);

    // Start and stop together while idle.
    i_start = 1'b1; i_stop = 1'b1;
    tick(1);
    i_start = 1'b0; i_stop = 1'b0;
    chk("startstop_busy", 64'(o_busy), 64'd0);
    w0 = wbit_seen;
    tick(30);
    chk("startstop_quiet", 64'(wbit_seen - w0), 64'd0);
    chk("startstop_count", 64'(o_wr_count), 64'd1);

    // External samples.
    start_run(1'b0, 1'b1, 4'hF, t0);
    ext_j = 0;
    wait_until(t0 + 8);
    ext_sample(64'hDEADBEEF_01234567, 1'b1);
    wait_until(t0 + 11);
    chk("ext_no_overrun", 64'(o_overrun), 64'd0);
    chk("ext_count1", 64'(o_wr_count), 64'd1);
    wait_until(t0 + 12);
    ext_sample({$urandom(), $urandom()}, 1'b1);
    ext_sample({$urandom(), $urandom()}, 1'b0);
    wait_until(t0 + 15);
    chk("ext_overrun", 64'(o_overrun), 64'd1);
    chk("ext_count2", 64'(o_wr_count), 64'd2);
    for (int k = 0; k < 8; k++) begin
      c = cyc + 1 + int'($urandom_range(0, 3));
      wait_until(c);
      ext_sample({$urandom(), $urandom()}, 1'b1);
    end
    tick(2);
    chk("ext_count10", 64'(o_wr_count), 64'd10);
    chk("ext_overrun_sticky", 64'(o_overrun), 64'd1);

    // Reset in the middle of a run.
    i_rst = 1'b1;
    tick(1);
    i_rst = 1'b0;
    chk_zero("midrun_reset");

    tick(5);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
